// File: rtl/mem_access_unit.sv
// Byte-serial load/store engine for RV32I LB/LH/LW/LBU/LHU/SB/SH/SW over an 8-bit memory port.
// Multi-byte accesses walk base..base+N-1 one byte per cycle; loads are assembled little-endian.
module mem_access_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] base_address,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] mem_address,
   output logic [7:0]  mem_write_data,
   output logic        mem_write_enable,
   input  logic [7:0]  mem_read_data
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      index_q, index_d;
   logic            store_q, store_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [31:0]     base_q, base_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0][7:0] rbuf_q, rbuf_d;
   logic [31:0]     load_data_q, load_data_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            error_q, error_d;
   logic [31:0]     mem_address_q, mem_address_d;
   logic [7:0]      mem_wdata_q, mem_wdata_d;
   logic            mem_we_q, mem_we_d;
   logic [1:0]      last_index;

   function automatic logic is_legal(input logic st, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (f3)
         3'b000, 3'b001, 3'b010: ok = 1'b1;
         3'b100, 3'b101:         ok = ~st;
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
      logic [31:0] r;
      case (f3)
         3'b000:  r = {{24{w[7]}}, w[7:0]};
         3'b100:  r = {24'h000000, w[7:0]};
         3'b001:  r = {{16{w[15]}}, w[15:0]};
         3'b101:  r = {16'h0000, w[15:0]};
         default: r = w;
      endcase
      return r;
   endfunction

   // Index of the final byte for the captured width code (N-1).
   always_comb begin
      case (funct3_q[1:0])
         2'b01:   last_index = 2'd1;
         2'b10:   last_index = 2'd3;
         default: last_index = 2'd0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      store_d     = store_q;
      funct3_d    = funct3_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      rbuf_d      = rbuf_q;
      load_data_d = load_data_q;
      error_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               store_d  = is_store;
               funct3_d = funct3;
               base_d   = base_address;
               wdata_d  = store_data;
               index_d  = 2'd0;
               if (is_legal(is_store, funct3)) begin
                  state_d = S_ACCESS;
               end else begin
                  state_d = S_DONE;
                  error_d = 1'b1;
               end
            end
         end
         S_ACCESS: begin
            if (!store_q) begin
               rbuf_d[index_q] = mem_read_data;
            end
            if (index_q == last_index) begin
               state_d = S_DONE;
               index_d = 2'd0;
               if (!store_q) begin
                  load_data_d = extend(funct3_q, rbuf_d);
               end
            end else begin
               index_d = index_q + 2'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            index_d = 2'd0;
         end
         default: begin
            state_d = S_IDLE;
            index_d = 2'd0;
         end
      endcase

      // Port outputs are registered, so they are decoded from the next state.
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      if (state_d == S_ACCESS) begin
         mem_address_d = base_d + {30'd0, index_d};
         mem_we_d      = store_d;
         mem_wdata_d   = store_d ? wdata_d[8*index_d +: 8] : 8'h00;
      end else begin
         mem_address_d = 32'h0000_0000;
         mem_we_d      = 1'b0;
         mem_wdata_d   = 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         index_q       <= 2'd0;
         store_q       <= 1'b0;
         funct3_q      <= 3'd0;
         base_q        <= 32'h0000_0000;
         wdata_q       <= 32'h0000_0000;
         rbuf_q        <= '0;
         load_data_q   <= 32'h0000_0000;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         mem_address_q <= 32'h0000_0000;
         mem_wdata_q   <= 8'h00;
         mem_we_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         index_q       <= index_d;
         store_q       <= store_d;
         funct3_q      <= funct3_d;
         base_q        <= base_d;
         wdata_q       <= wdata_d;
         rbuf_q        <= rbuf_d;
         load_data_q   <= load_data_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_we_q      <= mem_we_d;
      end
   end

   assign load_data        = load_data_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign error            = error_q;
   assign mem_address      = mem_address_q;
   assign mem_write_data   = mem_wdata_q;
   assign mem_write_enable = mem_we_q;

endmodule
